// File: rtl/branch_predictor.sv
// Bimodal branch predictor: PC-indexed table of 2-bit saturating counters with
// a combinational IF-stage guess, ID-stage training, misprediction flag and statistics.
module branch_predictor #(
    parameter int unsigned IDX_BITS   = 6,
    parameter logic [1:0]  INIT_STATE = 2'b01,
    parameter int unsigned CNT_BITS   = 32
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                IF_Valid,
    input  logic [31:0]         IF_PC,
    output logic                Pred_Taken,

    input  logic                ID_Valid,
    input  logic                ID_IsBranch,
    input  logic [31:0]         ID_PC,
    input  logic                ID_PredTaken,
    input  logic                Br,
    output logic                Mispredict,

    output logic [CNT_BITS-1:0] Br_Count,
    output logic [CNT_BITS-1:0] Miss_Count
);

    localparam int unsigned ENTRIES = 32'(1) << IDX_BITS;

    logic [1:0]          ctr_q [ENTRIES];
    logic [1:0]          ctr_d [ENTRIES];
    logic [CNT_BITS-1:0] br_cnt_q,   br_cnt_d;
    logic [CNT_BITS-1:0] miss_cnt_q, miss_cnt_d;

    logic [IDX_BITS-1:0] rd_idx;
    logic [IDX_BITS-1:0] wr_idx;
    logic                upd;
    logic                miss;

    // One step toward strong-taken or strong-not-taken, holding at the rails.
    function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic taken);
        logic [1:0] r;
        r = c;
        if (taken) begin
            if (c != 2'b11) r = c + 2'd1;
        end else begin
            if (c != 2'b00) r = c - 2'd1;
        end
        return r;
    endfunction

    function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
        return (&v) ? v : v + CNT_BITS'(1);
    endfunction

    assign rd_idx = IF_PC[IDX_BITS+1:2];
    assign wr_idx = ID_PC[IDX_BITS+1:2];
    assign upd    = ID_Valid & ID_IsBranch;
    assign miss   = upd & (Br ^ ID_PredTaken);

    // Pure table read; a same-cycle write is not bypassed.
    assign Pred_Taken = IF_Valid & ctr_q[rd_idx][1];
    assign Mispredict = miss;

    assign Br_Count   = br_cnt_q;
    assign Miss_Count = miss_cnt_q;

    // PC bits outside the index field carry no information for this table.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{IF_PC[31:IDX_BITS+2], IF_PC[1:0],
                              ID_PC[31:IDX_BITS+2], ID_PC[1:0]};

    always_comb begin
        ctr_d      = ctr_q;
        br_cnt_d   = br_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (upd) begin
            ctr_d[wr_idx] = ctr_step(ctr_q[wr_idx], Br);
            br_cnt_d      = sat_inc(br_cnt_q);
        end
        if (miss) begin
            miss_cnt_d = sat_inc(miss_cnt_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= INIT_STATE;
            end
            br_cnt_q   <= '0;
            miss_cnt_q <= '0;
        end else begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= ctr_d[i];
            end
            br_cnt_q   <= br_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: reset, training, saturation, aliasing,
// same-cycle read/write, mid-stream async reset and gated updates.
module tb_branch_predictor;

    logic        clk;
    logic        rst_n;
    logic        IF_Valid;
    logic [31:0] IF_PC;
    logic        Pred_Taken;
    logic        ID_Valid;
    logic        ID_IsBranch;
    logic [31:0] ID_PC;
    logic        ID_PredTaken;
    logic        Br;
    logic        Mispredict;
    logic [31:0] Br_Count;
    logic [31:0] Miss_Count;

    int n_total;
    int n_bad;

    branch_predictor #(
        .IDX_BITS   (6),
        .INIT_STATE (2'b01),
        .CNT_BITS   (32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .IF_Valid     (IF_Valid),
        .IF_PC        (IF_PC),
        .Pred_Taken   (Pred_Taken),
        .ID_Valid     (ID_Valid),
        .ID_IsBranch  (ID_IsBranch),
        .ID_PC        (ID_PC),
        .ID_PredTaken (ID_PredTaken),
        .Br           (Br),
        .Mispredict   (Mispredict),
        .Br_Count     (Br_Count),
        .Miss_Count   (Miss_Count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [31:0] pc, input logic pt, input logic br);
        ID_Valid     = 1'b1;
        ID_IsBranch  = 1'b1;
        ID_PC        = pc;
        ID_PredTaken = pt;
        Br           = br;
        #1;
    endtask

    task automatic clr_id();
        ID_Valid     = 1'b0;
        ID_IsBranch  = 1'b0;
        ID_PC        = 'x;
        ID_PredTaken = 1'bx;
        Br           = 1'bx;
        #1;
    endtask

    task automatic check_stats(input string tag, input int br_exp, input int miss_exp);
        check({tag, "_brcnt"},   Br_Count,   32'(br_exp));
        check({tag, "_misscnt"}, Miss_Count, 32'(miss_exp));
    endtask

    initial begin
        n_total      = 0;
        n_bad        = 0;
        rst_n        = 1'b0;
        IF_Valid     = 1'b1;
        IF_PC        = 32'h0040_0010;
        ID_Valid     = 1'b0;
        ID_IsBranch  = 1'b0;
        ID_PC        = '0;
        ID_PredTaken = 1'b0;
        Br           = 1'b0;
        #1;

        // 1: reset state
        check("t1_pred_rst", 32'(Pred_Taken), 32'd0);
        check_stats("t1_rst", 0, 0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 64; i++) begin
            IF_PC = 32'h0040_0000 + 32'(i) * 32'd4;
            #1;
            check($sformatf("t1_idx%0d", i), 32'(Pred_Taken), 32'd0);
        end
        tick();
        check_stats("t1_post", 0, 0);

        // 2: train 0x00400010 taken twice against a not-taken prediction
        IF_PC = 32'h0040_0010;
        set_id(32'h0040_0010, 1'b0, 1'b1);
        check("t2_miss_a", 32'(Mispredict), 32'd1);
        check("t2_pred_a", 32'(Pred_Taken), 32'd0);
        tick();
        check("t2_miss_b", 32'(Mispredict), 32'd1);
        check("t2_pred_b", 32'(Pred_Taken), 32'd1);
        tick();
        clr_id();
        check("t2_pred_c", 32'(Pred_Taken), 32'd1);
        check_stats("t2", 2, 2);

        // 3: saturation at index 8 (PC 0x00400020), fresh 01
        IF_PC = 32'h0040_0020;
        for (int i = 0; i < 5; i++) begin
            set_id(32'h0040_0020, 1'b1, 1'b1);
            check($sformatf("t3_inc_miss%0d", i), 32'(Mispredict), 32'd0);
            tick();
            clr_id();
            check($sformatf("t3_inc_pred%0d", i), 32'(Pred_Taken), 32'd1);
        end
        begin
            logic [3:0] dec_exp;
            dec_exp = 4'b0001;  // pred after each decrement: 10,01,00,00 -> 1,0,0,0
            for (int i = 0; i < 4; i++) begin
                set_id(32'h0040_0020, 1'b0, 1'b0);
                tick();
                clr_id();
                check($sformatf("t3_dec_pred%0d", i), 32'(Pred_Taken), 32'(dec_exp[i]));
            end
        end
        check_stats("t3", 11, 2);
        // from 00, two taken updates reach 10: first leaves 01 (pred 0)
        set_id(32'h0040_0020, 1'b0, 1'b1);
        tick();
        clr_id();
        check("t3_floor_pred", 32'(Pred_Taken), 32'd0);
        set_id(32'h0040_0020, 1'b0, 1'b1);
        tick();
        clr_id();
        check("t3_recover_pred", 32'(Pred_Taken), 32'd1);
        check_stats("t3_end", 13, 4);

        // 4: aliasing 0x00400110 onto index 4 (currently 11)
        IF_PC = 32'h0040_0010;
        set_id(32'h0040_0110, 1'b1, 1'b0);
        check("t4_miss", 32'(Mispredict), 32'd1);
        tick();
        clr_id();
        check("t4_pred_a", 32'(Pred_Taken), 32'd1);
        set_id(32'h0040_0110, 1'b1, 1'b0);
        tick();
        clr_id();
        check("t4_pred_b", 32'(Pred_Taken), 32'd0);
        check_stats("t4", 15, 6);

        // 5: same index read and written in one cycle (index 12, 01)
        IF_PC = 32'h0040_0030;
        set_id(32'h0040_0030, 1'b0, 1'b1);
        check("t5_pred_old", 32'(Pred_Taken), 32'd0);
        check("t5_miss", 32'(Mispredict), 32'd1);
        tick();
        clr_id();
        check("t5_pred_new", 32'(Pred_Taken), 32'd1);
        check_stats("t5", 16, 7);

        // 6a: gated prediction and gated updates
        IF_Valid = 1'b0;
        #1;
        check("t6_if_invalid", 32'(Pred_Taken), 32'd0);
        IF_Valid = 1'b1;
        ID_Valid = 1'b1; ID_IsBranch = 1'b0; ID_PC = 32'h0040_0030;
        ID_PredTaken = 1'b0; Br = 1'bx;
        #1;
        check("t6_notbr_miss", 32'(Mispredict), 32'd0);
        tick();
        ID_Valid = 1'b0; ID_IsBranch = 1'b1; ID_PC = 'x; ID_PredTaken = 1'bx; Br = 1'bx;
        #1;
        check("t6_noval_miss", 32'(Mispredict), 32'd0);
        tick();
        clr_id();
        check_stats("t6_gated", 16, 7);
        check("t6_gated_pred", 32'(Pred_Taken), 32'd1);

        // 6b: async reset mid-cycle with an update held active
        set_id(32'h0040_0030, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_stats("t6_rst_now", 0, 0);
        check("t6_rst_pred", 32'(Pred_Taken), 32'd0);
        check("t6_rst_miss", 32'(Mispredict), 32'd1);
        tick();
        tick();
        check_stats("t6_rst_hold", 0, 0);
        check("t6_rst_hold_pred", 32'(Pred_Taken), 32'd0);
        rst_n = 1'b1;
        #1;
        check_stats("t6_rel", 0, 0);
        check("t6_rel_pred", 32'(Pred_Taken), 32'd0);
        tick();
        clr_id();
        check_stats("t6_first", 1, 1);
        check("t6_first_pred", 32'(Pred_Taken), 32'd1);
        IF_PC = 32'h0040_0010;
        #1;
        check("t6_other_cleared", 32'(Pred_Taken), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
